// File: rtl/compress_shift_ctrl_pkg.sv
// rtl/compress_shift_ctrl_pkg.sv - shared types and constants for the block-shift controller
package compress_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_CALC
    } state_t;

    typedef logic [4:0] shift_t;

    localparam int DEF_MAX_SHIFT = 24;

    function automatic shift_t clip_shift(input int unsigned v, input int unsigned lim);
        return (v > lim) ? shift_t'(lim) : shift_t'(v);
    endfunction

endpackage

// File: rtl/compress_shift_ctrl_if.sv
// rtl/compress_shift_ctrl_if.sv - write-side framing, read-side pop and shift result bundle
interface compress_shift_ctrl_if
    import compress_shift_pkg::*;
#(
    parameter int IW = 40
);
    logic                 i_sop;
    logic                 i_eop;
    logic                 i_vld;
    logic signed [IW-1:0] i_din_re;
    logic signed [IW-1:0] i_din_im;
    logic                 i_rd_sop;
    shift_t               o_shift_num;
    logic                 o_shift_vld;
    logic                 o_ovf_err;
    logic                 o_udf_err;
`ifdef COMPRESS_SHIFT_CTRL_FORCE_EN
    logic                 i_force_en;
    shift_t               i_force_shift;

    modport master (output i_sop, i_eop, i_vld, i_din_re, i_din_im, i_rd_sop,
                    i_force_en, i_force_shift,
                    input  o_shift_num, o_shift_vld, o_ovf_err, o_udf_err);
    modport slave  (input  i_sop, i_eop, i_vld, i_din_re, i_din_im, i_rd_sop,
                    i_force_en, i_force_shift,
                    output o_shift_num, o_shift_vld, o_ovf_err, o_udf_err);
`else
    modport master (output i_sop, i_eop, i_vld, i_din_re, i_din_im, i_rd_sop,
                    input  o_shift_num, o_shift_vld, o_ovf_err, o_udf_err);
    modport slave  (input  i_sop, i_eop, i_vld, i_din_re, i_din_im, i_rd_sop,
                    output o_shift_num, o_shift_vld, o_ovf_err, o_udf_err);
`endif
endinterface

// File: rtl/compress_shift_ctrl_lzc.sv
// rtl/compress_shift_ctrl_lzc.sv - combinational leading-zero counter, all-zero input gives W
module lzc_count #(
    parameter int W  = 39,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] cnt
);

    // Ascending scan: the highest set bit is the last one to assign.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (d[i]) cnt = CW'(W - 1 - i);
        end
    end

endmodule

// File: rtl/compress_shift_ctrl.sv
// rtl/compress_shift_ctrl.sv - per-block magnitude shift finder with 2-deep shift queue; COMPRESS_SHIFT_CTRL_FORCE_EN adds a forced-shift override
module compress_shift_ctrl
    import compress_shift_pkg::*;
#(
    parameter int IW        = 40,
    parameter int OW        = 16,
    parameter int MAX_SHIFT = DEF_MAX_SHIFT
) (
    input logic                 clk,
    input logic                 rst,
    compress_shift_ctrl_if.slave bus
);

    localparam int AW = IW - 1;
    localparam int CW = $clog2(AW + 1);
    localparam int unsigned LIM = (MAX_SHIFT < IW - OW) ? MAX_SHIFT : IW - OW;

    state_t         state_q, state_d;
    logic [AW-1:0]  m_cur, acc_q, acc_d, snap_q;
    logic           close, snap_vld, lz_vld;
    logic [CW-1:0]  lz_cnt;
    shift_t         lz_q;

    // Sign-folded magnitude: the OR of all samples exposes the highest significant bit.
    assign m_cur = (bus.i_din_re[AW-1:0] ^ {AW{bus.i_din_re[IW-1]}})
                 | (bus.i_din_im[AW-1:0] ^ {AW{bus.i_din_im[IW-1]}});

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        close   = 1'b0;
        if (bus.i_vld) begin
            if (bus.i_sop) begin
                acc_d   = m_cur;
                state_d = ST_ACC;
            end else if (state_q == ST_ACC) begin
                acc_d = acc_q | m_cur;
            end
            if (bus.i_eop && (bus.i_sop || state_q == ST_ACC)) begin
                close   = 1'b1;
                state_d = ST_CALC;
            end
        end
        if (state_q == ST_CALC && !close && !(bus.i_vld && bus.i_sop) && lz_vld && !snap_vld)
            state_d = ST_IDLE;
    end

    lzc_count #(.W(AW), .CW(CW)) u_lzc (
        .d   (snap_q),
        .cnt (lz_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            snap_q   <= '0;
            snap_vld <= 1'b0;
            lz_q     <= '0;
            lz_vld   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            snap_vld <= close;
            if (close) snap_q <= acc_d;
            lz_vld   <= snap_vld;
            if (snap_vld) lz_q <= clip_shift(int'(lz_cnt), LIM);
        end
    end

    shift_t     mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] cnt_q;
    logic       push, pop, empty, full, bypass, do_rd, do_wr, ovf_set, udf_set;
    shift_t     num_q;
    logic       vld_q, ovf_q, udf_q;

    assign push    = lz_vld;
    assign pop     = bus.i_rd_sop;
    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign bypass  = pop && empty && push;
    assign do_rd   = pop && !empty;
    assign do_wr   = push && !bypass && (!full || do_rd);
    assign ovf_set = push && full && !do_rd;
    assign udf_set = pop && empty && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= 2'd0;
            num_q  <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= lz_q;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_rd) rd_ptr <= ~rd_ptr;
            cnt_q <= cnt_q + {1'b0, do_wr} - {1'b0, do_rd};
            if (pop) begin
`ifdef COMPRESS_SHIFT_CTRL_FORCE_EN
                if (bus.i_force_en) begin
                    num_q <= clip_shift(int'(bus.i_force_shift), LIM);
                    vld_q <= 1'b1;
                end else
`endif
                if (bypass) begin
                    num_q <= lz_q;
                    vld_q <= 1'b1;
                end else if (do_rd) begin
                    num_q <= mem[rd_ptr];
                    vld_q <= 1'b1;
                end else begin
                    vld_q <= 1'b0;
                end
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (udf_set) udf_q <= 1'b1;
        end
    end

    assign bus.o_shift_num = num_q;
    assign bus.o_shift_vld = vld_q;
    assign bus.o_ovf_err   = ovf_q;
    assign bus.o_udf_err   = udf_q;

endmodule

// File: tb/tb_compress_shift_ctrl.sv
// tb/tb_compress_shift_ctrl.sv - scoreboard bench for compress_shift_ctrl
module tb_compress_shift_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    compress_shift_ctrl_if #(.IW(40)) bus ();

    compress_shift_ctrl #(.IW(40), .OW(16), .MAX_SHIFT(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    int          exp_q[$];
    logic [4:0]  last_num = '0;
    logic        exp_ovf  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic samp(input logic sop, input logic eop, input logic vld,
                        input logic [39:0] re, input logic [39:0] im);
        bus.i_sop    = sop;
        bus.i_eop    = eop;
        bus.i_vld    = vld;
        bus.i_din_re = re;
        bus.i_din_im = im;
        tick();
        bus.i_sop = 1'b0;
        bus.i_eop = 1'b0;
        bus.i_vld = 1'b0;
    endtask

    task automatic expect_push(input int exp);
        if (exp_q.size() < 2) exp_q.push_back(exp);
        else exp_ovf = 1'b1;
    endtask

    task automatic blk(input int n, input int pk, input logic [39:0] pre, input logic [39:0] pim,
                       input logic [39:0] fre, input logic [39:0] fim, input int exp);
        for (int k = 0; k < n; k++)
            samp(k == 0, k == n - 1, 1'b1, (k == pk) ? pre : fre, (k == pk) ? pim : fim);
        expect_push(exp);
    endtask

    task automatic pop_chk(input string tag);
        int e;
        bus.i_rd_sop = 1'b1;
        tick();
        bus.i_rd_sop = 1'b0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_num"}, bus.o_shift_num, e);
            check({tag, "_vld"}, bus.o_shift_vld, 1);
            last_num = 5'(e);
        end else begin
            check({tag, "_hold"}, bus.o_shift_num, last_num);
            check({tag, "_vld0"}, bus.o_shift_vld, 0);
            check({tag, "_udf"}, bus.o_udf_err, 1);
        end
    endtask

    task automatic bypass_chk(input string tag);
        int e;
        bus.i_rd_sop = 1'b1;
        tick();
        check({tag, "_early_vld"}, bus.o_shift_vld, 0);
        check({tag, "_early_num"}, bus.o_shift_num, last_num);
        tick();
        bus.i_rd_sop = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_num"}, bus.o_shift_num, e);
        check({tag, "_vld"}, bus.o_shift_vld, 1);
        last_num = 5'(e);
    endtask

    initial begin
        bus.i_sop = 0; bus.i_eop = 0; bus.i_vld = 0; bus.i_rd_sop = 0;
        bus.i_din_re = '0; bus.i_din_im = '0;
`ifdef COMPRESS_SHIFT_CTRL_FORCE_EN
        bus.i_force_en = 1'b0; bus.i_force_shift = '0;
`endif
        idle(2);
        rst = 1'b0;
        check("rst_num", bus.o_shift_num, 0);
        check("rst_vld", bus.o_shift_vld, 0);
        check("rst_ovf", bus.o_ovf_err, 0);
        check("rst_udf", bus.o_udf_err, 0);

        pop_chk("udf_empty");

        blk(8, 3, 40'h00_0080_0000, 40'h0, 40'd5, -40'sd3, 15);
        bypass_chk("peak15");

        blk(4, 0, 40'h0, 40'h0, 40'h0, 40'h0, 24);
        idle(3); pop_chk("zero24");
        blk(4, 0, 40'h0, '1, 40'h0, '1, 24);
        idle(3); pop_chk("imneg24");
        blk(4, 1, 40'h7F_FFFF_FFFF, 40'h0, 40'h0, 40'h0, 0);
        idle(3); pop_chk("full0");
        blk(1, 0, 40'h00_0200_0000, 40'h0, 40'h0, 40'h0, 13);
        idle(3); pop_chk("single13");

        samp(1, 0, 1, 40'h40_0000_0000, 40'h0);
        samp(0, 0, 1, 40'h1, 40'h0);
        samp(1, 0, 1, 40'h0, 40'h0);
        samp(0, 0, 0, 40'h7F_FFFF_FFFF, 40'h0);
        samp(0, 0, 1, 40'h00_0010_0000, 40'h0);
        samp(0, 1, 1, 40'h0, 40'h3);
        expect_push(18);
        samp(0, 0, 1, 40'h7F_FFFF_FFFF, 40'h0);
        samp(0, 1, 1, 40'h7F_FFFF_FFFF, 40'h0);
        idle(3); pop_chk("restart18");

        blk(3, 1, 40'h08_0000_0000, 40'h0, 40'h0, 40'h0, 3);
        idle(3);
        blk(3, 2, 40'h0, 40'hFF_EFFF_FFFF, 40'h0, 40'h0, 10);
        idle(3);
        check("ovf_before", bus.o_ovf_err, exp_ovf);
        blk(2, 0, 40'h02_0000_0000, 40'h0, 40'h0, 40'h0, 5);
        idle(3);
        check("ovf_after", bus.o_ovf_err, exp_ovf);
        check("ovf_model", exp_ovf, 1);
        pop_chk("fifo3");
        pop_chk("fifo10");
        pop_chk("lost");

        blk(2, 1, 40'h00_8000_0000, 40'h0, 40'h0, 40'h0, 7);
        bypass_chk("bypass7");

        samp(1, 0, 1, 40'h10_0000_0000, 40'h0);
        samp(0, 1, 1, 40'h0, 40'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        last_num = '0;
        exp_ovf  = 1'b0;
        check("mrst_num", bus.o_shift_num, 0);
        check("mrst_vld", bus.o_shift_vld, 0);
        check("mrst_ovf", bus.o_ovf_err, 0);
        check("mrst_udf", bus.o_udf_err, 0);
        idle(4);
        pop_chk("mrst_drop");
        blk(4, 2, 40'h00_0000_0100, 40'h0, 40'h0, 40'h0, 24);
        idle(3); pop_chk("clip24");

`ifdef COMPRESS_SHIFT_CTRL_FORCE_EN
        bus.i_force_en = 1'b1; bus.i_force_shift = 5'd31;
        bus.i_rd_sop = 1'b1;
        tick();
        bus.i_rd_sop = 1'b0; bus.i_force_en = 1'b0;
        check("force_num", bus.o_shift_num, 24);
        check("force_vld", bus.o_shift_vld, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/compress_shift_ctrl.md
COMPRESS_SHIFT_CTRL -- requirements
Module: compress_shift_ctrl

Interface
REQ-001 Parameters SHALL be: IW, default 40, input sample width per I/Q component; OW, default 16, compressed output width; MAX_SHIFT, default 24 (IW-OW), upper clip for the shift value.
REQ-002 Port clk, input, 1 bit, clock; all logic SHALL be rising-edge.
REQ-003 Port rst, input, 1 bit, reset; synchronous, active-high.
REQ-004 Ports i_sop/i_eop/i_vld, input, 1 bit each, write-side block framing; qualified by i_vld.
REQ-005 Ports i_din_re/i_din_im, input, IW bits each, signed two's-complement write-side samples.
REQ-006 Port i_rd_sop, input, 1 bit, start of the same block on the delayed (read) side of the compressor.
REQ-007 Port o_shift_num, output, 5 bits, shift applied to the current read-side block.
REQ-008 Port o_shift_vld, output, 1 bit, o_shift_num belongs to a measured block.
REQ-009 Ports o_ovf_err/o_udf_err, output, 1 bit each, sticky queue overflow/underflow flags.

Function
REQ-010 Per sample, with i_vld=1, the block SHALL form m = x XOR {IW{x[IW-1]}} for re and im, then OR both into a running accumulator acc[IW-2:0].
REQ-011 i_sop&i_vld SHALL load acc with that sample's m, discarding prior contents; sop without a preceding eop restarts the block.
REQ-012 i_eop&i_vld SHALL include that sample, then close the block; sop and eop on the same sample form a 1-sample block.
REQ-013 Samples with i_vld=0 SHALL be ignored; vld outside sop..eop SHALL NOT alter acc.
REQ-014 On close: lz = leading-zero count of acc[IW-2:0]; shift = min(lz, MAX_SHIFT); acc=0 gives MAX_SHIFT.
REQ-015 The shift SHALL be pushed into a 2-entry FIFO exactly 2 cycles after the eop cycle (register the acc snapshot, register the LZ result, then push).
REQ-016 FSM states: IDLE (no open block), ACC (block open), CALC (2-cycle LZ pipeline); transitions IDLE->ACC on sop, ACC->CALC on eop, CALC->IDLE after push; a sop in CALC SHALL open a new block in ACC while the pipeline completes independently.
REQ-017 i_rd_sop SHALL pop the FIFO head; o_shift_num/o_shift_vld update the cycle after i_rd_sop, then hold until the next pop.
REQ-018 A simultaneous push and pop SHALL both take effect; a pop from an empty FIFO sees the same-cycle push (bypass).
REQ-019 A push into a full FIFO SHALL drop the new value and set o_ovf_err.
REQ-020 A pop from an empty FIFO with no same-cycle push SHALL hold o_shift_num, drive o_shift_vld=0 and set o_udf_err.
REQ-021 Error flags SHALL clear only on rst.

Reset
REQ-022 rst SHALL clear acc, the FSM (to IDLE), the LZ pipeline and the FIFO pointers, and set o_shift_num=0, o_shift_vld=0, o_ovf_err=0, o_udf_err=0; it takes effect mid-block and discards any in-flight shift.

Configuration
REQ-023 Macro COMPRESS_SHIFT_CTRL_FORCE_EN, when defined, SHALL add inputs i_force_en (1 bit) and i_force_shift (5 bits).
REQ-024 With the macro defined and i_force_en=1 at pop, the block SHALL output i_force_shift clipped to MAX_SHIFT with o_shift_vld=1; the FIFO still pops.
REQ-025 Without the macro, the ports and logic SHALL be absent.

Structure
REQ-026 A package compress_shift_pkg SHALL hold the FSM state enum, the 5-bit shift typedef and the default MAX_SHIFT constant.
REQ-027 One sub-module, lzc_count (parameterised leading-zero counter, combinational, registered by the parent), SHALL implement REQ-014.

Verification
REQ-028 Block of 8 samples with peak re=+0x00_0080_0000 -> shift 15 pushed at eop+2; o_shift_num=15 the cycle after i_rd_sop.
REQ-029 All-zero block -> shift 24; block with im=-1 only -> 24; block with re=0x7F_FFFF_FFFF -> 0.
REQ-030 Two blocks (shifts 3 and 10) before any i_rd_sop, then two pops -> outputs 3 then 10; a third block before any pop -> o_ovf_err=1, and the third value is lost.
REQ-031 i_rd_sop with an empty FIFO -> o_shift_vld=0, o_shift_num unchanged, o_udf_err=1; i_rd_sop coinciding with a push of 7 -> o_shift_num=7 with o_shift_vld=1.
REQ-032 rst asserted mid-block after a peak of 0x10_0000_0000 -> outputs 0; next block with peak 0x00_0000_0100 -> shift 24 (MAX_SHIFT clip; raw LZ 30).
REQ-033 With the macro defined: i_force_en=1, i_force_shift=31 -> o_shift_num=24; without the macro, the build SHALL compile with no force ports.
